// File: rtl/sdes_block_engine.sv
// sdes_block_engine: multi-byte S-DES engine, two cycles per byte.
// ECB or CBC, encrypt or decrypt, valid/ready handshake on both sides.
module sdes_block_engine #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] in_data,
    input  logic [9:0]          in_key,
    input  logic                in_decrypt,
    input  logic                in_cbc,
    input  logic [7:0]          in_iv,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] out_data
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    // S-box entries packed row-major, entry {row,col} at bits [2*idx +: 2]
    localparam logic [31:0] S0_TAB = 32'hB7D8_1BB1;
    localparam logic [31:0] S1_TAB = 32'hC613_D2E4;

    typedef enum logic [1:0] {IDLE, R1, R2, DONE} state_t;

    state_t state;
    state_t state_nx;

    logic [8*NBYTES-1:0] blk_q;
    logic [9:0]          key_q;
    logic                dec_q;
    logic                cbc_q;
    logic [7:0]          iv_q;
    logic [7:0]          chain_q;
    logic [7:0]          mid_q;
    logic [IW-1:0]       idx;

    logic [9:0] key_p;
    logic [9:0] key_ls1;
    logic [9:0] key_ls3;
    logic [7:0] k1;
    logic [7:0] k2;
    logic [7:0] ka;
    logic [7:0] kb;
    logic [7:0] cur_byte;
    logic [7:0] chain_use;
    logic [7:0] r1_in;
    logic [7:0] r1_fk;
    logic [7:0] r1_out;
    logic [7:0] r2_raw;
    logic [7:0] r2_out;
    logic [7:0] chain_nx;

    function automatic logic [9:0] p10(input logic [9:0] k);
        return {k[7], k[5], k[8], k[3], k[6],
                k[0], k[9], k[1], k[2], k[4]};
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] k);
        return {k[4], k[7], k[3], k[6],
                k[2], k[5], k[0], k[1]};
    endfunction

    function automatic logic [4:0] rol1(input logic [4:0] h);
        return {h[3:0], h[4]};
    endfunction

    function automatic logic [4:0] rol2(input logic [4:0] h);
        return {h[2:0], h[4:3]};
    endfunction

    function automatic logic [7:0] ip(input logic [7:0] x);
        return {x[6], x[2], x[5], x[7],
                x[4], x[0], x[3], x[1]};
    endfunction

    function automatic logic [7:0] ipinv(input logic [7:0] x);
        return {x[4], x[7], x[5], x[3],
                x[1], x[6], x[0], x[2]};
    endfunction

    function automatic logic [7:0] ep(input logic [3:0] r);
        return {r[0], r[3], r[2], r[1],
                r[2], r[1], r[0], r[3]};
    endfunction

    function automatic logic [3:0] p4(input logic [3:0] s);
        return {s[2], s[0], s[1], s[3]};
    endfunction

    function automatic logic [1:0] sbox(
        input logic [31:0] tab,
        input logic [3:0]  v
    );
        logic [4:0] sel;
        sel = {v[3], v[0], v[2], v[1], 1'b0};
        return tab[sel +: 2];
    endfunction

    function automatic logic [7:0] fk(
        input logic [7:0] x,
        input logic [7:0] k
    );
        logic [7:0] e;
        logic [3:0] p;
        e = ep(x[3:0]) ^ k;
        p = p4({sbox(S0_TAB, e[7:4]), sbox(S1_TAB, e[3:0])});
        return {x[7:4] ^ p, x[3:0]};
    endfunction

    assign key_p   = p10(key_q);
    assign key_ls1 = {rol1(key_p[9:5]), rol1(key_p[4:0])};
    assign key_ls3 = {rol2(key_ls1[9:5]), rol2(key_ls1[4:0])};
    assign k1      = p8(key_ls1);
    assign k2      = p8(key_ls3);

    // decryption runs the same rounds with the subkeys swapped
    assign ka = dec_q ? k2 : k1;
    assign kb = dec_q ? k1 : k2;

    // select the byte currently being processed
    always_comb begin
        cur_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx == IW'(i)) cur_byte = blk_q[8*i +: 8];
        end
    end

    // the first byte chains off the captured iv
    assign chain_use = (idx == '0) ? iv_q : chain_q;

    assign r1_in  = (cbc_q && !dec_q) ? (cur_byte ^ chain_use) : cur_byte;
    assign r1_fk  = fk(ip(r1_in), ka);
    assign r1_out = {r1_fk[3:0], r1_fk[7:4]};

    assign r2_raw = ipinv(fk(mid_q, kb));
    assign r2_out = (cbc_q && dec_q) ? (r2_raw ^ chain_use) : r2_raw;

    // chain carries the ciphertext byte in both directions
    assign chain_nx = dec_q ? cur_byte : r2_out;

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // next state and handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = R1;
            end
            R1: state_nx = R2;
            R2: state_nx = (idx == LAST) ? DONE : R1;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // capture, per-byte round registers and result assembly
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blk_q    <= '0;
            key_q    <= '0;
            dec_q    <= 1'b0;
            cbc_q    <= 1'b0;
            iv_q     <= '0;
            chain_q  <= '0;
            mid_q    <= '0;
            idx      <= '0;
            out_data <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                blk_q <= in_data;
                key_q <= in_key;
                dec_q <= in_decrypt;
                cbc_q <= in_cbc;
                iv_q  <= in_iv;
                idx   <= '0;
            end
            if (state == R1) mid_q <= r1_out;
            if (state == R2) begin
                chain_q <= chain_nx;
                for (int i = 0; i < NBYTES; i++) begin
                    if (idx == IW'(i)) out_data[8*i +: 8] <= r2_out;
                end
                if (idx != LAST) idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdes_block_engine.sv
// tb_sdes_block_engine: directed vectors on a 1-byte and a 4-byte engine.
// Expected values from constants and a small table-based S-DES model.
module tb_sdes_block_engine;

    typedef struct {
        logic        dec;
        logic        cbc;
        logic [9:0]  key;
        logic [7:0]  iv;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        rstn;

    logic        a_in_valid;
    logic        a_in_ready;
    logic [7:0]  a_in_data;
    logic [9:0]  a_in_key;
    logic        a_in_decrypt;
    logic        a_in_cbc;
    logic [7:0]  a_in_iv;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [7:0]  a_out_data;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [31:0] b_in_data;
    logic [9:0]  b_in_key;
    logic        b_in_decrypt;
    logic        b_in_cbc;
    logic [7:0]  b_in_iv;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [31:0] b_out_data;

    int passed;
    int total;

    int s0t[4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0},
                      '{0, 2, 1, 3}, '{3, 1, 3, 2}};
    int s1t[4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3},
                      '{3, 0, 1, 0}, '{2, 1, 0, 3}};

    sdes_block_engine #(.NBYTES(1)) u_a (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .in_data    (a_in_data),
        .in_key     (a_in_key),
        .in_decrypt (a_in_decrypt),
        .in_cbc     (a_in_cbc),
        .in_iv      (a_in_iv),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .out_data   (a_out_data)
    );

    sdes_block_engine #(.NBYTES(4)) u_b (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_data    (b_in_data),
        .in_key     (b_in_key),
        .in_decrypt (b_in_decrypt),
        .in_cbc     (b_in_cbc),
        .in_iv      (b_in_iv),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_data   (b_out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // bit p (1-based, MSB first) of an n-bit value
    function automatic logic pb(input logic [9:0] x, input int n, input int p);
        return x[4'(n - p)];
    endfunction

    function automatic logic [7:0] m_sub(input logic [9:0] k, input bit second);
        logic [9:0] p;
        logic [4:0] l;
        logic [4:0] r;
        p = {pb(k,10,3), pb(k,10,5), pb(k,10,2), pb(k,10,7), pb(k,10,4),
             pb(k,10,10), pb(k,10,1), pb(k,10,9), pb(k,10,8), pb(k,10,6)};
        l = p[9:5];
        r = p[4:0];
        l = {l[3:0], l[4]};
        r = {r[3:0], r[4]};
        if (second) begin
            l = {l[2:0], l[4:3]};
            r = {r[2:0], r[4:3]};
        end
        p = {l, r};
        return {pb(p,10,6), pb(p,10,3), pb(p,10,7), pb(p,10,4),
                pb(p,10,8), pb(p,10,5), pb(p,10,10), pb(p,10,9)};
    endfunction

    function automatic logic [7:0] m_fk(input logic [7:0] x, input logic [7:0] k);
        logic [9:0] r;
        logic [9:0] w;
        logic [7:0] e;
        logic [3:0] s;
        logic [3:0] p;
        logic [1:0] row;
        logic [1:0] col;
        r = {6'd0, x[3:0]};
        e = {pb(r,4,4), pb(r,4,1), pb(r,4,2), pb(r,4,3),
             pb(r,4,2), pb(r,4,3), pb(r,4,4), pb(r,4,1)} ^ k;
        row = {e[7], e[4]};
        col = {e[6], e[5]};
        s[3:2] = 2'(s0t[row][col]);
        row = {e[3], e[0]};
        col = {e[2], e[1]};
        s[1:0] = 2'(s1t[row][col]);
        w = {6'd0, s};
        p = {pb(w,4,2), pb(w,4,4), pb(w,4,3), pb(w,4,1)};
        return {x[7:4] ^ p, x[3:0]};
    endfunction

    function automatic logic [7:0] m_sdes(input logic [7:0] x, input logic [9:0] k, input bit dec);
        logic [9:0] w;
        logic [7:0] t;
        w = {2'd0, x};
        t = {pb(w,8,2), pb(w,8,6), pb(w,8,3), pb(w,8,1),
             pb(w,8,4), pb(w,8,8), pb(w,8,5), pb(w,8,7)};
        t = m_fk(t, m_sub(k, dec));
        t = {t[3:0], t[7:4]};
        t = m_fk(t, m_sub(k, !dec));
        w = {2'd0, t};
        return {pb(w,8,4), pb(w,8,1), pb(w,8,3), pb(w,8,5),
                pb(w,8,7), pb(w,8,2), pb(w,8,8), pb(w,8,6)};
    endfunction

    function automatic logic [31:0] m_block(input vec_t v);
        logic [31:0] res;
        logic [7:0]  ch;
        logic [7:0]  b;
        logic [7:0]  y;
        ch = v.iv;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            b = v.data[8*i +: 8];
            if (v.cbc && !v.dec) begin
                y = m_sdes(b ^ ch, v.key, 1'b0);
                ch = y;
            end else if (v.cbc && v.dec) begin
                y = m_sdes(b, v.key, 1'b1) ^ ch;
                ch = b;
            end else begin
                y = m_sdes(b, v.key, v.dec);
            end
            res[8*i +: 8] = y;
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    task automatic start(input vec_t v);
        @(negedge clk);
        chk("idle_ready_a", 64'(a_in_ready), 64'(1));
        chk("idle_ready_b", 64'(b_in_ready), 64'(1));
        a_in_data    = v.data[7:0];
        a_in_key     = v.key;
        a_in_decrypt = v.dec;
        a_in_cbc     = v.cbc;
        a_in_iv      = v.iv;
        b_in_data    = v.data;
        b_in_key     = v.key;
        b_in_decrypt = v.dec;
        b_in_cbc     = v.cbc;
        b_in_iv      = v.iv;
        a_in_valid   = 1'b1;
        b_in_valid   = 1'b1;
        @(posedge clk);
        #1;
        // later input changes must not reach the computation
        a_in_valid   = 1'b0;
        b_in_valid   = 1'b0;
        a_in_data    = ~a_in_data;
        b_in_data    = ~b_in_data;
        a_in_key     = ~a_in_key;
        b_in_key     = ~b_in_key;
        a_in_decrypt = ~a_in_decrypt;
        b_in_decrypt = ~b_in_decrypt;
        a_in_cbc     = ~a_in_cbc;
        b_in_cbc     = ~b_in_cbc;
        a_in_iv      = ~a_in_iv;
        b_in_iv      = ~b_in_iv;
    endtask

    // edges counted with the accept edge as edge 1; 0 means never seen
    task automatic wait_done(output int la, output int lb);
        bit sa;
        bit sb;
        sa = 1'b0;
        sb = 1'b0;
        la = 0;
        lb = 0;
        for (int e = 2; e <= 60 && !(sa && sb); e++) begin
            @(posedge clk);
            #1;
            if (!sa && a_out_valid) begin sa = 1'b1; la = e; end
            if (!sb && b_out_valid) begin sb = 1'b1; lb = e; end
        end
    endtask

    task automatic pop();
        @(negedge clk);
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        b_out_ready = 1'b0;
        chk("pop_ready_a", 64'({a_in_ready, a_out_valid}), 64'(2'b10));
        chk("pop_ready_b", 64'({b_in_ready, b_out_valid}), 64'(2'b10));
    endtask

    task automatic reset_state(input string tag);
        chk({tag, "_a"}, 64'({a_in_ready, a_out_valid, a_out_data}), 64'({1'b1, 1'b0, 8'h00}));
        chk({tag, "_b"}, 64'({b_in_ready, b_out_valid, b_out_data}), 64'({1'b1, 1'b0, 32'h0}));
    endtask

    vec_t        vecs[8];
    logic [31:0] cbc_ct;
    logic [31:0] hold;
    int          la;
    int          lb;
    int          seen;

    initial begin
        passed = 0;
        total  = 0;
        rstn = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_key = '0;
        a_in_decrypt = 1'b0; a_in_cbc = 1'b0; a_in_iv = '0;
        a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_key = '0;
        b_in_decrypt = 1'b0; b_in_cbc = 1'b0; b_in_iv = '0;
        b_out_ready = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 10'b1010000010, 8'h00, 32'h9797_9797, 32'h3838_3838};
        vecs[1] = '{1'b1, 1'b0, 10'b1010000010, 8'h00, 32'h3838_3838, 32'h9797_9797};
        vecs[2] = '{1'b0, 1'b0, 10'b1010000010, 8'h00, 32'h00FF_A55A, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 10'b1010000010, 8'h00, 32'h9797_9797, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 10'b1010000010, 8'h00, 32'h0, 32'h9797_9797};
        vecs[5] = '{1'b0, 1'b1, 10'h3FF, 8'h5A, 32'h1234_5678, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 10'h155, 8'h00, 32'hDEAD_BEEF, 32'h0};
        vecs[7] = '{1'b1, 1'b1, 10'h0F0, 8'hC3, 32'h0102_0304, 32'h0};
        vecs[2].exp  = m_block(vecs[2]);
        vecs[3].exp  = m_block(vecs[3]);
        vecs[4].data = vecs[3].exp;
        vecs[5].exp  = m_block(vecs[5]);
        vecs[6].exp  = m_block(vecs[6]);
        vecs[7].exp  = m_block(vecs[7]);

        repeat (3) @(negedge clk);
        reset_state("reset");
        rstn = 1'b1;

        cbc_ct = '0;
        for (int i = 0; i < 8; i++) begin
            start(vecs[i]);
            wait_done(la, lb);
            chk($sformatf("lat_a_%0d", i), 64'(la), 64'(3));
            chk($sformatf("lat_b_%0d", i), 64'(lb), 64'(9));
            chk($sformatf("data_a_%0d", i), 64'(a_out_data), 64'(vecs[i].exp[7:0]));
            chk($sformatf("data_b_%0d", i), 64'(b_out_data), 64'(vecs[i].exp));
            if (i == 3) cbc_ct = b_out_data;
            pop();
        end

        chk("cbc_byte0", 64'(cbc_ct[7:0]), 64'(8'h38));
        chk("cbc_not_equal",
            64'((cbc_ct[7:0] == cbc_ct[15:8]) && (cbc_ct[15:8] == cbc_ct[23:16]) &&
                (cbc_ct[23:16] == cbc_ct[31:24])), 64'(0));

        // backpressure: hold DONE for 20 cycles with a competing request
        start(vecs[0]);
        wait_done(la, lb);
        hold = b_out_data;
        chk("bp_entry", 64'(hold), 64'(32'h3838_3838));
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_data  = 32'h1111_1111;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold_%0d", c),
                64'({b_out_valid, b_in_ready, b_out_data}),
                64'({1'b1, 1'b0, hold}));
        end
        @(negedge clk);
        b_in_valid = 1'b0;
        pop();

        // reset while byte 2 is in its second round
        start(vecs[3]);
        repeat (5) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        reset_state("midreset");
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (a_out_valid || b_out_valid) seen++;
        end
        chk("abort_no_valid", 64'(seen), 64'(0));
        start(vecs[3]);
        wait_done(la, lb);
        chk("after_reset_lat", 64'(lb), 64'(9));
        chk("after_reset_data", 64'(b_out_data), 64'(vecs[3].exp));
        pop();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
